// File: rtl/input_request_ctrl_pkg.sv
// Shared types and defaults for the CPU input-request controller.
// Holds the controller state encoding and the counter-width helper.
package input_request_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      WAIT_RELEASE = 3'd1,
      WAIT_PRESS   = 3'd2,
      ACK          = 3'd3,
      WAIT_DROP    = 3'd4
   } state_t;

   localparam int unsigned DEFAULT_DEBOUNCE_CYC = 500000;
   localparam int unsigned DEFAULT_TIMEOUT_CYC  = 0;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-run debouncer for a raw button.
// The debounced level flips only after DEBOUNCE_CYC consecutive disagreeing samples.
module btn_debounce
   import input_request_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic btn_db
);

   localparam int unsigned        CNT_W    = cnt_width(DEBOUNCE_CYC);
   localparam int unsigned        LAST_IDX = (DEBOUNCE_CYC == 0) ? 0 : DEBOUNCE_CYC - 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(LAST_IDX);

   logic             sync_q1;
   logic             sync_q2;
   logic [CNT_W-1:0] cnt;

   // Metastability guard for the asynchronous button.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= btn_in;
         sync_q2 <= sync_q1;
      end
   end

   // Any sample matching the current level restarts the run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         btn_db <= 1'b0;
      end else if (sync_q2 == btn_db) begin
         cnt    <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt    <= '0;
         btn_db <= sync_q2;
      end else begin
         cnt    <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/input_request_ctrl.sv
// Serves CPU input requests from a switch bank, gated by a debounced Enter button.
// A press already held when a request arrives must be released before it counts.
module input_request_ctrl
   import input_request_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
   parameter int unsigned TIMEOUT_CYC  = DEFAULT_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_enter,
   input  logic [DATA_W-1:0] sw,
   input  logic              in_req,
   output logic              in_ack,
   output logic [DATA_W-1:0] in_data,
   output logic              in_timeout,
   output logic              waiting
);

   localparam int unsigned       WAIT_W     = cnt_width(TIMEOUT_CYC);
   localparam int unsigned       WAIT_IDX   = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(WAIT_IDX);
   localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(TIMEOUT_CYC);
   localparam bit                TIMEOUT_EN = (TIMEOUT_CYC != 0);

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              btn_db;
   logic              timeout_hit;

   btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_btn_debounce (
      .clk    (clk),
      .reset  (reset),
      .btn_in (btn_enter),
      .btn_db (btn_db)
   );

   // Fires in the wait cycle that completes TIMEOUT_CYC cycles of waiting.
   assign timeout_hit = TIMEOUT_EN && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         in_ack     <= 1'b0;
         in_data    <= '0;
         in_timeout <= 1'b0;
         waiting    <= 1'b0;
      end else begin
         in_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (in_req) begin
                  state    <= btn_db ? WAIT_RELEASE : WAIT_PRESS;
                  wait_cnt <= '0;
                  waiting  <= 1'b1;
               end
            end

            WAIT_RELEASE: begin
               if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
               if (!in_req) begin
                  state   <= IDLE;
                  waiting <= 1'b0;
               end else if (timeout_hit) begin
                  state      <= ACK;
                  in_ack     <= 1'b1;
                  in_data    <= '0;
                  in_timeout <= 1'b1;
                  waiting    <= 1'b0;
               end else if (!btn_db) begin
                  state <= WAIT_PRESS;
               end
            end

            // A fresh press takes priority over a coincident timeout.
            WAIT_PRESS: begin
               if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
               if (!in_req) begin
                  state   <= IDLE;
                  waiting <= 1'b0;
               end else if (btn_db) begin
                  state      <= ACK;
                  in_ack     <= 1'b1;
                  in_data    <= sw;
                  in_timeout <= 1'b0;
                  waiting    <= 1'b0;
               end else if (timeout_hit) begin
                  state      <= ACK;
                  in_ack     <= 1'b1;
                  in_data    <= '0;
                  in_timeout <= 1'b1;
                  waiting    <= 1'b0;
               end
            end

            ACK: begin
               state <= WAIT_DROP;
            end

            WAIT_DROP: begin
               if (!in_req) state <= IDLE;
            end

            default: begin
               state   <= IDLE;
               waiting <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_input_request_ctrl.sv
// Randomized and directed checks of input_request_ctrl against a behavioural model.
module tb_input_request_ctrl;
   import input_request_ctrl_pkg::*;

   localparam int unsigned DW = 16;
   localparam int unsigned DB = 4;
   localparam int unsigned TO = 50;

   logic          clk = 1'b0;
   logic          reset;
   logic          btn_enter;
   logic [DW-1:0] sw;
   logic          in_req;
   logic          in_ack;
   logic [DW-1:0] in_data;
   logic          in_timeout;
   logic          waiting;

   input_request_ctrl #(
      .DATA_W       (DW),
      .DEBOUNCE_CYC (DB),
      .TIMEOUT_CYC  (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_enter  (btn_enter),
      .sw         (sw),
      .in_req     (in_req),
      .in_ack     (in_ack),
      .in_data    (in_data),
      .in_timeout (in_timeout),
      .waiting    (waiting)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural reference: request bookkeeping flags plus a sample-window debouncer.
   bit          e_ack, e_to, e_wait;
   logic [DW-1:0] e_data;
   bit          m_in_wait, m_need_rel, m_drop_wait;
   int          m_wait_cycles;
   bit          m_sync1, m_sync2, m_db;
   bit          hist[$];

   function automatic void model_reset();
      e_ack = 0; e_to = 0; e_wait = 0; e_data = '0;
      m_in_wait = 0; m_need_rel = 0; m_drop_wait = 0; m_wait_cycles = 0;
      m_sync1 = 0; m_sync2 = 0; m_db = 0;
      hist.delete();
   endfunction

   function automatic void model_step();
      bit s, all_diff;
      if (reset) begin
         model_reset();
         return;
      end
      if (e_ack) begin
         e_ack = 0;
         m_drop_wait = 1;
      end else if (m_drop_wait) begin
         if (!in_req) m_drop_wait = 0;
      end else if (m_in_wait) begin
         m_wait_cycles++;
         if (!in_req) m_in_wait = 0;
         else if (!m_need_rel && m_db) begin
            e_ack = 1; e_data = sw; e_to = 0; m_in_wait = 0;
         end else if (m_wait_cycles == int'(TO)) begin
            e_ack = 1; e_data = '0; e_to = 1; m_in_wait = 0;
         end else if (m_need_rel && !m_db) m_need_rel = 0;
      end else if (in_req) begin
         m_in_wait = 1; m_need_rel = m_db; m_wait_cycles = 0;
      end
      e_wait = m_in_wait;
      // Debounced level flips when the last DB samples all disagree with it.
      s = m_sync2; m_sync2 = m_sync1; m_sync1 = btn_enter;
      hist.push_back(s);
      if (hist.size() > DB) void'(hist.pop_front());
      if (hist.size() == DB) begin
         all_diff = 1;
         foreach (hist[i]) if (hist[i] == m_db) all_diff = 0;
         if (all_diff) m_db = !m_db;
      end
   endfunction

   int          tick_no = 0;
   int          acks, ack_tick;
   logic [DW-1:0] ack_data;
   logic        ack_to;

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      tick_no++;
      chk("in_ack", 32'(in_ack), 32'(e_ack));
      chk("in_data", 32'(in_data), 32'(e_data));
      chk("in_timeout", 32'(in_timeout), 32'(e_to));
      chk("waiting", 32'(waiting), 32'(e_wait));
      if (in_ack) begin
         acks++; ack_tick = tick_no; ack_data = in_data; ack_to = in_timeout;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear_stats();
      acks = 0; ack_tick = -1; ack_data = '0; ack_to = 1'b0;
   endtask

   int  t0;
   int  btn_left;
   bit  seen_ack;

   initial begin
      reset = 1'b1; btn_enter = 1'b0; sw = '0; in_req = 1'b0;
      model_reset();
      clear_stats();
      @(negedge clk);
      chk("rst_ack", 32'(in_ack), 32'h0);
      chk("rst_data", 32'(in_data), 32'h0);
      chk("rst_timeout", 32'(in_timeout), 32'h0);
      chk("rst_waiting", 32'(waiting), 32'h0);
      run(2);
      reset = 1'b0;
      run(5);

      // Basic request with a clean press.
      clear_stats();
      sw = 16'hA5C3; in_req = 1'b1; btn_enter = 1'b1; t0 = tick_no;
      run(10);
      btn_enter = 1'b0;
      run(5);
      in_req = 1'b0;
      run(10);
      chk("basic_acks", 32'(acks), 32'd1);
      chk("basic_data", 32'(ack_data), 32'hA5C3);
      chk("basic_to", 32'(ack_to), 32'h0);
      chk("basic_latency", 32'(ack_tick - t0), 32'd7);

      // Bouncing button: only the final stable level counts.
      clear_stats();
      sw = 16'h3C0F; in_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         btn_enter = (i % 2 == 0);
         run(2);
      end
      btn_enter = 1'b1; t0 = tick_no;
      run(12);
      btn_enter = 1'b0; in_req = 1'b0;
      run(10);
      chk("bounce_acks", 32'(acks), 32'd1);
      chk("bounce_latency", 32'(ack_tick - t0), 32'd7);
      chk("bounce_data", 32'(ack_data), 32'h3C0F);

      // Press held over from before the request.
      clear_stats();
      sw = 16'h0F0F; btn_enter = 1'b1;
      run(10);
      in_req = 1'b1;
      run(10);
      chk("held_no_ack", 32'(acks), 32'd0);
      btn_enter = 1'b0;
      run(10);
      btn_enter = 1'b1;
      run(10);
      chk("held_acks", 32'(acks), 32'd1);
      chk("held_data", 32'(ack_data), 32'h0F0F);
      btn_enter = 1'b0; in_req = 1'b0;
      run(10);

      // Pure timeout.
      clear_stats();
      sw = 16'h1234; in_req = 1'b1; t0 = tick_no;
      run(55);
      chk("to_acks", 32'(acks), 32'd1);
      chk("to_flag", 32'(ack_to), 32'h1);
      chk("to_data", 32'(ack_data), 32'h0);
      chk("to_latency", 32'(ack_tick - t0), 32'd51);
      in_req = 1'b0;
      run(10);

      // Press debounced exactly on the last wait cycle beats the timeout.
      clear_stats();
      sw = 16'h5A5A; in_req = 1'b1; t0 = tick_no;
      run(44);
      btn_enter = 1'b1;
      run(12);
      chk("race_acks", 32'(acks), 32'd1);
      chk("race_flag", 32'(ack_to), 32'h0);
      chk("race_data", 32'(ack_data), 32'h5A5A);
      chk("race_latency", 32'(ack_tick - t0), 32'd51);
      btn_enter = 1'b0; in_req = 1'b0;
      run(10);

      // Abort by dropping the request, then a late press.
      clear_stats();
      sw = 16'hFFFF; in_req = 1'b1;
      run(10);
      in_req = 1'b0;
      run(1);
      btn_enter = 1'b1;
      run(10);
      btn_enter = 1'b0;
      run(10);
      chk("abort_acks", 32'(acks), 32'd0);
      chk("abort_data", 32'(in_data), 32'h5A5A);

      // Reset while waiting, with the button held across it.
      in_req = 1'b1;
      run(10);
      btn_enter = 1'b1;
      run(8);
      reset = 1'b1;
      #1;
      model_reset();
      chk("midrst_ack", 32'(in_ack), 32'h0);
      chk("midrst_data", 32'(in_data), 32'h0);
      chk("midrst_timeout", 32'(in_timeout), 32'h0);
      chk("midrst_waiting", 32'(waiting), 32'h0);
      chk("midrst_state", 32'(dut.state), 32'(IDLE));
      in_req = 1'b0;
      run(3);
      reset = 1'b0;
      clear_stats();
      in_req = 1'b1;
      run(12);
      chk("postrst_acks", 32'(acks), 32'd1);
      in_req = 1'b0; btn_enter = 1'b0;
      run(10);

      // Randomized traffic.
      clear_stats();
      btn_left = 0; seen_ack = 0;
      for (int c = 0; c < 3000; c++) begin
         if (btn_left == 0) begin
            btn_enter = ~btn_enter;
            btn_left = int'($urandom_range(1, 12));
         end
         btn_left--;
         if (!in_req) begin
            if ($urandom_range(0, 9) == 0) begin
               in_req = 1'b1; sw = DW'($urandom); seen_ack = 0;
            end
         end else if ($urandom_range(0, 99) < (seen_ack ? 30 : 1)) begin
            in_req = 1'b0;
         end
         tick();
         if (in_ack) seen_ack = 1;
      end
      chk("random_some_acks", 32'(acks > 0), 32'h1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/input_request_ctrl.md
INPUT_REQUEST_CTRL -- requirements
Module: input_request_ctrl

Interface
REQ-001 Parameter DATA_W, 16, width of the switch bank and the returned data word.
REQ-002 Parameter DEBOUNCE_CYC, 500000, stable cycles required before the debounced button level changes (about 50 ms at 10 MHz).
REQ-003 Parameter TIMEOUT_CYC, 0, wait cycles before a timeout ack is issued; 0 disables timeout.
REQ-004 Clock clk is input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 Reset reset is input, 1 bit, asynchronous, active-high.
REQ-006 Port btn_enter is input, 1 bit, raw asynchronous user button, active-high.
REQ-007 Port sw is input, DATA_W bits, user switch bank, quasi-static.
REQ-008 Port in_req is input, 1 bit, CPU input request, held high until in_ack is seen.
REQ-009 Port in_ack is output, 1 bit, single-cycle acknowledge pulse.
REQ-010 Port in_data is output, DATA_W bits, captured switch word, valid from the in_ack cycle until the next capture.
REQ-011 Port in_timeout is output, 1 bit, high with in_ack when the ack is a timeout.
REQ-012 Port waiting is output, 1 bit, high in WAIT_RELEASE and WAIT_PRESS (CPU stall and user LED).

Function
REQ-013 btn_enter shall pass through a 2-flop synchronizer, then a debouncer, producing btn_db.
- btn_db changes only after the synchronized input differs from btn_db for DEBOUNCE_CYC consecutive cycles.
- Any intermediate match clears the count.
REQ-014 The FSM shall have states IDLE, WAIT_RELEASE, WAIT_PRESS, ACK and WAIT_DROP.
REQ-015 In IDLE with in_req=1, the next state shall be WAIT_RELEASE if btn_db=1, else WAIT_PRESS.
- A press held over from a previous request is never consumed twice.
REQ-016 WAIT_RELEASE -> WAIT_PRESS when btn_db=0.
REQ-017 WAIT_PRESS -> ACK in the cycle btn_db=1.
- sw is captured into in_data on that same clock edge.
- in_timeout is cleared on that same edge.
REQ-018 In ACK, in_ack=1 for exactly one cycle, then the FSM goes to WAIT_DROP.
REQ-019 WAIT_DROP -> IDLE when in_req=0; no new request is accepted until then.
REQ-020 With TIMEOUT_CYC!=0, a wait counter runs in WAIT_RELEASE and WAIT_PRESS and clears on entry from IDLE.
- On reaching TIMEOUT_CYC, the FSM goes to ACK with in_data=0 and in_timeout=1.
REQ-021 If a press and a timeout occur in the same cycle, the press wins (data captured, in_timeout=0).
REQ-022 If in_req drops in WAIT_RELEASE or WAIT_PRESS, the FSM returns to IDLE without ack and in_data is unchanged.
REQ-023 Button activity in IDLE, ACK or WAIT_DROP shall be ignored and not buffered.
REQ-024 Latency: in_ack rises exactly 1 cycle after the cycle btn_db first reads 1 in WAIT_PRESS.
REQ-025 The wait counter shall be sized for TIMEOUT_CYC, saturate, and never wrap.

Reset
REQ-026 Reset shall force the FSM to IDLE and clear the synchronizer, debouncer counter, btn_db and wait counter.
- Outputs reset to: in_ack=0, in_data=0, in_timeout=0, waiting=0.
REQ-027 Reset asserted mid-wait or mid-ack shall abort immediately with no ack; after release, btn_db restarts at 0.

Structure
REQ-028 A shared package shall hold the FSM state typedef (3-bit encoding) and the default DEBOUNCE_CYC/TIMEOUT_CYC constants.
REQ-029 The synchronizer plus debouncer shall be one sub-module, btn_debounce, parameterized by DEBOUNCE_CYC, with output btn_db.
- The controller FSM, capture register and timeout counter stay in input_request_ctrl.

Verification (DEBOUNCE_CYC=4, TIMEOUT_CYC=50, DATA_W=16)
REQ-030 Basic request: sw=16'hA5C3, in_req=1, clean press held 10 cycles.
- Expect one in_ack pulse, in_data=16'hA5C3, in_timeout=0, waiting low from the ack cycle.
- Raise in_req again only after it has been low.
REQ-031 Bounce rejection: in_req=1, button toggles every 2 cycles for 20 cycles, then held.
- Expect exactly one in_ack, only after 4 stable-high cycles plus sync delay.
REQ-032 Held-over press: button held from before in_req rises.
- Expect no ack until the button is released (debounced) and pressed again.
REQ-033 Timeout: in_req=1, no press for 50 wait cycles.
- Expect in_ack with in_timeout=1 and in_data=0.
- A press landing on the 50th cycle gives in_timeout=0 with data captured.
REQ-034 Abort: drop in_req while in WAIT_PRESS, then press.
- Expect no in_ack and in_data unchanged.
- Then assert reset mid-wait: all outputs 0, FSM in IDLE.
